// File: rtl/mapper_registers.sv
// Write side and 16x16 register file of the card's memory mapper, plus the bank map lookup.
// Define MAPPER_READBACK_EN to let the host read the registers back over the 8-bit data lanes.
module mapper_registers #(
    parameter logic [15:0] REG_BASE = 16'h4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cycle_begin,
    input  logic [15:0] i_address,
    input  logic        memen,
    input  logic        dbin,
    input  logic        we,
    input  logic        a15,
    input  logic [7:0]  i_data_bus,
    output logic [7:0]  o_data_bus,
    output logic        o_data_oe,
    input  logic        i_regs_en,
    input  logic        i_map_en,
    input  logic [3:0]  bank_sel,
    output logic [6:0]  bank_address,
    output logic        bank_mapped,
    output logic        bank_readonly
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WR_LO,
        WR_HI
    } state_t;

    state_t state, state_next;

    // Each entry keeps only the stored bits: {mapped, readonly, page[6:0]}.
    logic [8:0]  regs [16];
    logic [3:0]  idx;
    logic [7:0]  lo;

    logic        memen_meta, memen_sync;
    logic        we_meta, we_sync, we_prev;
    logic        we_fall;
    logic        hit;
    logic        commit;
    logic        stage_lo;
    logic        latch_idx;
    logic [15:0] commit_word;
    logic [15:0] cur_word;
    logic        unused_addr_bit;

    assign unused_addr_bit = i_address[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memen_meta <= 1'b1;
            memen_sync <= 1'b1;
            we_meta    <= 1'b1;
            we_sync    <= 1'b1;
            we_prev    <= 1'b1;
        end else begin
            memen_meta <= memen;
            memen_sync <= memen_meta;
            we_meta    <= we;
            we_sync    <= we_meta;
            we_prev    <= we_sync;
        end
    end

    assign we_fall  = ~we_sync & we_prev;
    assign hit      = i_cycle_begin & ~memen & i_regs_en
                      & (i_address[15:5] == REG_BASE[15:5]);
    assign cur_word = {regs[idx][8:7], 7'b0000000, regs[idx][6:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A rising synchronized memen always wins over a same-cycle byte strobe.
    always_comb begin
        state_next  = state;
        commit      = 1'b0;
        commit_word = 16'h0000;
        stage_lo    = 1'b0;
        latch_idx   = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    latch_idx = 1'b1;
                    if (dbin) begin
`ifdef MAPPER_READBACK_EN
                        state_next = READ;
`else
                        state_next = IDLE;
`endif
                    end else begin
                        state_next = WR_LO;
                    end
                end
            end
            READ: begin
                if (memen_sync) begin
                    state_next = IDLE;
                end
            end
            WR_LO: begin
                if (memen_sync) begin
                    state_next = IDLE;
                end else if (we_fall) begin
                    if (a15) begin
                        stage_lo   = 1'b1;
                        state_next = WR_HI;
                    end else begin
                        commit      = 1'b1;
                        commit_word = {i_data_bus, cur_word[7:0]};
                        state_next  = IDLE;
                    end
                end
            end
            WR_HI: begin
                if (memen_sync) begin
                    state_next = IDLE;
                end else if (we_fall && !a15) begin
                    commit      = 1'b1;
                    commit_word = {i_data_bus, lo};
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= 4'd0;
            lo  <= 8'h00;
        end else begin
            if (latch_idx) begin
                idx <= i_address[4:1];
            end
            if (stage_lo) begin
                lo <= i_data_bus;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 16; n++) begin
                regs[n] <= 9'd0;
            end
        end else if (commit) begin
            regs[idx] <= {commit_word[15:14], commit_word[6:0]};
        end
    end

`ifdef MAPPER_READBACK_EN
    // Read data follows raw a15 so the host sees the byte it selects with no clock delay.
    always_comb begin
        o_data_bus = 8'h00;
        o_data_oe  = 1'b0;
        if (state == READ) begin
            o_data_bus = a15 ? cur_word[7:0] : cur_word[15:8];
            o_data_oe  = dbin & ~memen;
        end
    end
`else
    assign o_data_bus = 8'h00;
    assign o_data_oe  = 1'b0;
`endif

    // Transparent mode maps the 32K expansion banks 2, 3 and A-F one-to-one.
    always_comb begin
        bank_mapped   = 1'b0;
        bank_readonly = 1'b0;
        bank_address  = 7'd0;
        if (i_map_en) begin
            bank_mapped   = regs[bank_sel][8];
            bank_readonly = regs[bank_sel][7];
            bank_address  = regs[bank_sel][6:0];
        end else begin
            bank_address = {3'b000, bank_sel};
            bank_mapped  = (bank_sel == 4'd2) || (bank_sel == 4'd3) || (bank_sel >= 4'hA);
        end
    end

endmodule
